// File: rtl/pwm_multi_channel_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pwm_multi_channel_if                                         |
// | Description : Register-bus and output bundle for pwm_multi_channel.        |
// |               master = register-bank side, slave = PWM generator side.     |
// | Signals     : ena          design enable (low freezes the generator)       |
// |               wr_en        single-cycle register write strobe              |
// |               wr_addr      register write address                          |
// |               wr_data      register write data                             |
// |               rd_addr      readback address                                |
// |               rd_data      registered readback of the shadow register      |
// |               pwm_out      registered PWM outputs                          |
// |               period_start one-cycle pulse on every update event           |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface pwm_multi_channel_if #(
  parameter int CHANNELS = 8,
  parameter int WIDTH    = 8,
  parameter int ADDR_W   = 4
);
  logic                ena;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [WIDTH-1:0]    wr_data;
  logic [ADDR_W-1:0]   rd_addr;
  logic [WIDTH-1:0]    rd_data;
  logic [CHANNELS-1:0] pwm_out;
  logic                period_start;

  modport master (
    output ena, wr_en, wr_addr, wr_data, rd_addr,
    input  rd_data, pwm_out, period_start
  );

  modport slave (
    input  ena, wr_en, wr_addr, wr_data, rd_addr,
    output rd_data, pwm_out, period_start
  );
endinterface
`default_nettype wire

// File: rtl/pwm_multi_channel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pwm_multi_channel                                            |
// | Description : N-channel PWM generator with programmable period, prescaler  |
// |               and enable mask. Duty/period/prescale/mask are written to    |
// |               shadow registers and copied to the active set only on an     |
// |               update event (period wrap) or while ena is low, so outputs   |
// |               never glitch mid-period.                                     |
// | Ports       : clk    system clock                                          |
// |               rst_n  asynchronous active-low reset                         |
// |               bus    pwm_multi_channel_if.slave (register bus + outputs)   |
// | Reg map     : 0..CHANNELS-1 duty, CHANNELS period, CHANNELS+1 prescale,    |
// |               CHANNELS+2 enable mask, CHANNELS+3 mode (optional)           |
// | Option      : PWM_CENTER_ALIGNED_EN adds the center-aligned mode register  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module pwm_multi_channel #(
  parameter int CHANNELS   = 8,
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4,
  parameter int ADDR_W     = 4
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  pwm_multi_channel_if.slave   bus
);

  localparam logic [ADDR_W-1:0] ADDR_PERIOD   = ADDR_W'(CHANNELS);
  localparam logic [ADDR_W-1:0] ADDR_PRESCALE = ADDR_W'(CHANNELS + 1);
  localparam logic [ADDR_W-1:0] ADDR_MASK     = ADDR_W'(CHANNELS + 2);
`ifdef PWM_CENTER_ALIGNED_EN
  localparam logic [ADDR_W-1:0] ADDR_MODE     = ADDR_W'(CHANNELS + 3);
`endif

  // shadow (bus-visible) and active (generator-visible) register sets
  logic [CHANNELS-1:0][WIDTH-1:0] duty_q, duty_act_q;
  logic [WIDTH-1:0]               period_q, period_act_q;
  logic [PRESCALE_W-1:0]          prescale_q, prescale_act_q;
  logic [CHANNELS-1:0]            mask_q, mask_act_q;
`ifdef PWM_CENTER_ALIGNED_EN
  logic                           mode_q, mode_act_q;
  logic                           dir_q, dir_d;   // 0 = counting up
`endif

  logic [PRESCALE_W-1:0]          pre_cnt_q, pre_cnt_d;
  logic [WIDTH-1:0]               cnt_q, cnt_d;
  logic [CHANNELS-1:0]            pwm_q, pwm_d;
  logic [WIDTH-1:0]               rd_q, rd_d;
  logic                           tick;
  logic                           update;
  logic                           load_act;

  // prescaler and main counter
  always_comb begin
    tick      = bus.ena && (pre_cnt_q == prescale_act_q);
    pre_cnt_d = (!bus.ena || tick) ? '0 : pre_cnt_q + PRESCALE_W'(1);
    cnt_d     = cnt_q;
    update    = 1'b0;
`ifdef PWM_CENTER_ALIGNED_EN
    dir_d     = dir_q;
`endif
    if (!bus.ena) begin
      cnt_d = '0;
`ifdef PWM_CENTER_ALIGNED_EN
      dir_d = 1'b0;
`endif
    end else if (tick) begin
`ifdef PWM_CENTER_ALIGNED_EN
      // center mode: 0..P up, P-1..1 down, update on the step back to 0
      if (mode_act_q && (period_act_q != '0)) begin
        if (!dir_q) begin
          if (cnt_q == period_act_q) begin
            if (period_act_q == WIDTH'(1)) begin
              cnt_d  = '0;
              update = 1'b1;
            end else begin
              cnt_d = cnt_q - WIDTH'(1);
              dir_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + WIDTH'(1);
          end
        end else if (cnt_q == WIDTH'(1)) begin
          cnt_d  = '0;
          dir_d  = 1'b0;
          update = 1'b1;
        end else begin
          cnt_d = cnt_q - WIDTH'(1);
        end
      end else
`endif
      if (cnt_q == period_act_q) begin
        cnt_d  = '0;
        update = 1'b1;
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
      end
    end
  end

  // while disabled the active set tracks the shadows so ena rising starts clean
  assign load_act = !bus.ena || update;

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      pwm_d[i] = bus.ena && mask_act_q[i] && (cnt_q < duty_act_q[i]);
    end
  end

  // readback reflects the shadow value before any write on the same edge
  always_comb begin
    rd_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (bus.rd_addr == ADDR_W'(i)) rd_d = duty_q[i];
    end
    if (bus.rd_addr == ADDR_PERIOD)   rd_d = period_q;
    if (bus.rd_addr == ADDR_PRESCALE) rd_d = WIDTH'(prescale_q);
    if (bus.rd_addr == ADDR_MASK)     rd_d = WIDTH'(mask_q);
`ifdef PWM_CENTER_ALIGNED_EN
    if (bus.rd_addr == ADDR_MODE)     rd_d = WIDTH'(mode_q);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_q         <= '0;
      duty_act_q     <= '0;
      period_q       <= '1;
      period_act_q   <= '1;
      prescale_q     <= '0;
      prescale_act_q <= '0;
      mask_q         <= '0;
      mask_act_q     <= '0;
`ifdef PWM_CENTER_ALIGNED_EN
      mode_q         <= 1'b0;
      mode_act_q     <= 1'b0;
      dir_q          <= 1'b0;
`endif
      pre_cnt_q      <= '0;
      cnt_q          <= '0;
      pwm_q          <= '0;
      rd_q           <= '0;
    end else begin
      // active load samples the pre-write shadow, so a write colliding with
      // an update event takes effect from the following period
      if (load_act) begin
        duty_act_q     <= duty_q;
        period_act_q   <= period_q;
        prescale_act_q <= prescale_q;
        mask_act_q     <= mask_q;
`ifdef PWM_CENTER_ALIGNED_EN
        mode_act_q     <= mode_q;
`endif
      end
      for (int i = 0; i < CHANNELS; i++) begin
        if (bus.wr_en && (bus.wr_addr == ADDR_W'(i))) duty_q[i] <= bus.wr_data;
      end
      if (bus.wr_en && (bus.wr_addr == ADDR_PERIOD))   period_q   <= bus.wr_data;
      if (bus.wr_en && (bus.wr_addr == ADDR_PRESCALE)) prescale_q <= bus.wr_data[PRESCALE_W-1:0];
      if (bus.wr_en && (bus.wr_addr == ADDR_MASK))     mask_q     <= bus.wr_data[CHANNELS-1:0];
`ifdef PWM_CENTER_ALIGNED_EN
      if (bus.wr_en && (bus.wr_addr == ADDR_MODE))     mode_q     <= bus.wr_data[0];
      dir_q          <= dir_d;
`endif
      pre_cnt_q      <= pre_cnt_d;
      cnt_q          <= cnt_d;
      pwm_q          <= pwm_d;
      rd_q           <= rd_d;
    end
  end

  assign bus.pwm_out      = pwm_q;
  assign bus.period_start = update;
  assign bus.rd_data      = rd_q;

endmodule
`default_nettype wire
